signed_bcd_converter: RTL and testbench

Sequential converter that takes a sign/magnitude pair (sign bit plus `bits`-bit unsigned magnitude) and produces a sign flag plus packed BCD digits for the seven-segment display path. It sits directly downstream of the two's-complement-to-sign/magnitude stage and upstream of the digit multiplexer. It uses iterative shift-and-add-3 (double dabble), one magnitude bit per clock, with a start/busy/done handshake.

---
 rtl/signed_bcd_converter.sv | 113 +++++++++++
 tb/tb_signed_bcd_converter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/signed_bcd_converter.sv
// Sign/magnitude to packed BCD converter using iterative double dabble,
// one magnitude bit per clock, with a start/busy/done handshake.
module signed_bcd_converter #(
  parameter int unsigned bits   = 8,
  parameter int unsigned digits = 3
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic                  sign,
  input  logic [bits-1:0]       value,
  output logic                  busy,
  output logic                  done,
  output logic                  signOut,
  output logic [4*digits-1:0]   bcd
);

  localparam int unsigned BCD_W = 4 * digits;
  localparam int unsigned SH_W  = BCD_W + bits;
  localparam int unsigned CNT_W = $clog2(bits + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [SH_W-1:0]     sh, sh_nxt;
  logic                sgn, sgn_nxt;
  logic                nz, nz_nxt;
  logic                busy_nxt, done_nxt, sign_out_nxt;
  logic [BCD_W-1:0]    bcd_nxt;
  logic [BCD_W-1:0]    acc_adj;
  logic [SH_W-1:0]     sh_step;

  function automatic logic [3:0] adj_digit(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Add-3 correction on every accumulator digit before the shift
  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < int'(digits); i++) begin
      acc_adj[4*i +: 4] = adj_digit(sh[bits + 4*i +: 4]);
    end
  end

  // Magnitude MSB moves into accumulator bit 0
  assign sh_step = {acc_adj[BCD_W-2:0], sh[bits-1:0], 1'b0};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      sgn     <= 1'b0;
      nz      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      signOut <= 1'b0;
      bcd     <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sh      <= sh_nxt;
      sgn     <= sgn_nxt;
      nz      <= nz_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      signOut <= sign_out_nxt;
      bcd     <= bcd_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sh_nxt       = sh;
    sgn_nxt      = sgn;
    nz_nxt       = nz;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    sign_out_nxt = signOut;
    bcd_nxt      = bcd;
    case (state)
      IDLE: begin
        if (start) begin
          sh_nxt    = {BCD_W'(0), value};
          cnt_nxt   = CNT_W'(bits);
          sgn_nxt   = sign;
          nz_nxt    = |value;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sh_nxt  = sh_step;
        cnt_nxt = cnt - CNT_W'(1);
        // Last shift: publish result; negative zero reports as positive
        if (cnt == CNT_W'(1)) begin
          bcd_nxt      = sh_step[SH_W-1 -: BCD_W];
          sign_out_nxt = sgn & nz;
          done_nxt     = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Scoreboard bench for signed_bcd_converter: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_signed_bcd_converter;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic        sign;
  logic [7:0]  value;
  logic        busy, done, signOut;
  logic [11:0] bcd;

  typedef struct packed {
    logic [11:0] bcd;
    logic        s;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   busy_run = 0;
  logic prev_done = 1'b0;

  signed_bcd_converter #(.bits(8), .digits(3)) dut (
    .clk(clk), .resetN(resetN), .start(start), .sign(sign), .value(value),
    .busy(busy), .done(done), .signOut(signOut), .bcd(bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every done pulse against the scoreboard
  always @(negedge clk) begin
    if (!resetN) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        chk("done_single_cycle", 32'(prev_done), 32'd0);
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("bcd", 32'(bcd), 32'(e.bcd));
          chk("signOut", 32'(signOut), 32'(e.s));
          chk("busy_cycles", 32'(busy_run), 32'd8);
        end
        busy_run = 0;
      end
      prev_done = done;
    end
  end

  // Drive a one-cycle start; inputs scrambled afterwards to prove capture
  task automatic issue(input logic s, input logic [7:0] v, input logic push, input logic [11:0] eb, input logic es);
    start = 1'b1; sign = s; value = v;
    if (push) q.push_back('{bcd: eb, s: es});
    @(posedge clk); #1;
    start = 1'b0; sign = $urandom_range(0, 1); value = 8'($urandom);
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int t1, t2;
    resetN = 1'b0; start = 1'b0; sign = 1'b0; value = '0;

    // Reset with random inputs: outputs must stay at reset values
    for (int i = 0; i < 3; i++) begin
      start = $urandom_range(0, 1); sign = $urandom_range(0, 1); value = 8'($urandom);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_signOut", 32'(signOut), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
    end
    @(posedge clk); #1;
    resetN = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_bcd", 32'(bcd), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Maximum value
    issue(1'b0, 8'd255, 1'b1, 12'h255, 1'b0);
    chk("busy_after_capture", 32'(busy), 32'd1);
    wait_done(t1);

    // Negative values
    issue(1'b1, 8'd128, 1'b1, 12'h128, 1'b1);
    wait_done(t1);
    issue(1'b1, 8'd7, 1'b1, 12'h007, 1'b1);
    wait_done(t1);

    // Negative zero reports positive
    issue(1'b1, 8'd0, 1'b1, 12'h000, 1'b0);
    wait_done(t1);

    // Start mid-conversion is ignored
    issue(1'b0, 8'd99, 1'b1, 12'h099, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    issue(1'b0, 8'd42, 1'b0, 12'h000, 1'b0);
    wait_done(t1);

    // Start during the done cycle is accepted
    issue(1'b0, 8'd9, 1'b1, 12'h009, 1'b0);
    wait_done(t2);
    chk("back_to_back_interval", 32'(t2 - t1), 32'd9);

    // Reset mid-conversion aborts without a done pulse
    issue(1'b0, 8'd200, 1'b0, 12'h000, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    resetN = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_result", 32'(bcd), 32'd0);

    issue(1'b0, 8'd100, 1'b1, 12'h100, 1'b0);
    wait_done(t1);
    repeat (2) @(posedge clk);
    #1;
    chk("result_held", 32'(bcd), 32'h100);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
